fir_mac_engine: RTL and testbench

Parametrised, multi-channel, time-multiplexed FIR filter: one multiplier and one accumulator serve TAPS taps for each of CHANNELS independent sample streams. Samples and results move over valid/ready handshakes, and coefficients are loaded at run time. It is the next-generation FIR datapath and controller in one block, sitting between the sample source and the output sink.

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_history_buf.sv | 74 +++++++
 rtl/fir_mac_engine.sv | 153 +++++++++++++++
 tb/tb_fir_mac_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for the fir_mac_engine block.
//   state_t      - controller states IDLE, MAC, DRAIN, OUT
//   clog2_min1() - clog2-derived field width, never narrower than 1 bit
//   sat_to_width() - clamps a wide signed value into the signed range of out_w bits
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Working width for saturation; accumulators must stay narrower than this.
    localparam int unsigned SAT_MAX_W = 128;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
        input logic signed [SAT_MAX_W-1:0] v,
        input int unsigned                 out_w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1);
        lo = ~hi;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/fir_history_buf.sv
// fir_history_buf: per-channel circular sample history for the FIR engine.
//   clk, rst_n        - clock, asynchronous active-low reset
//   clear             - synchronous: write pointers and fill counts return to 0
//   wr_en/wr_chan/wr_data - append a sample to a channel's history
//   rd_chan/rd_k      - channel and tap index k to read
//   rd_data           - x[newest-k] of that channel, or 0 when k >= fill count
// Sample memory itself is never cleared; the fill count masks stale entries.
module fir_history_buf
    import fir_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned TAPS     = 64,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 wr_en,
    input  logic [clog2_min1(CHANNELS)-1:0]      wr_chan,
    input  logic signed [IN_W-1:0]               wr_data,
    input  logic [clog2_min1(CHANNELS)-1:0]      rd_chan,
    input  logic [clog2_min1(TAPS)-1:0]          rd_k,
    output logic signed [IN_W-1:0]               rd_data
);

    localparam int unsigned TAP_W  = clog2_min1(TAPS);
    localparam int unsigned FILL_W = clog2_min1(TAPS + 1);
    localparam logic [TAP_W:0] TAPS_X = (TAP_W + 1)'(TAPS);

    logic signed [IN_W-1:0] mem [CHANNELS][TAPS];
    logic [TAP_W-1:0]       wp_q   [CHANNELS];
    logic [FILL_W-1:0]      fill_q [CHANNELS];

    logic [TAP_W-1:0] wp_r;
    logic [TAP_W-1:0] newest;
    logic [TAP_W:0]   n_ext;
    logic [TAP_W:0]   k_ext;
    logic [TAP_W:0]   idx_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wp_q[c]   <= '0;
                fill_q[c] <= '0;
            end
        end else if (clear) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wp_q[c]   <= '0;
                fill_q[c] <= '0;
            end
        end else if (wr_en) begin
            wp_q[wr_chan] <= (wp_q[wr_chan] == TAP_W'(TAPS - 1)) ? '0
                                                                : wp_q[wr_chan] + TAP_W'(1);
            if (fill_q[wr_chan] != FILL_W'(TAPS))
                fill_q[wr_chan] <= fill_q[wr_chan] + FILL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear)
            mem[wr_chan][wp_q[wr_chan]] <= wr_data;
    end

    // Newest sample sits one slot behind the write pointer; walk backwards by k.
    always_comb begin
        wp_r    = wp_q[rd_chan];
        newest  = (wp_r == '0) ? TAP_W'(TAPS - 1) : wp_r - TAP_W'(1);
        n_ext   = {1'b0, newest};
        k_ext   = {1'b0, rd_k};
        idx_ext = (n_ext >= k_ext) ? n_ext - k_ext : n_ext + TAPS_X - k_ext;
        rd_data = (FILL_W'(rd_k) < fill_q[rd_chan]) ? mem[rd_chan][idx_ext[TAP_W-1:0]] : '0;
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: multi-channel time-multiplexed FIR (one multiplier, one accumulator).
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - synchronous abort; empties all channel histories
//   in_valid/in_ready/in_data/in_chan    - sample input handshake
//   out_valid/out_ready/out_data/out_chan - result output handshake
//   coef_we/coef_addr/coef_data          - coefficient write, honoured only when idle
//   busy                - high whenever the controller is not IDLE
// Build option: FIR_SAT_EN saturates out_data to OUT_W bits; otherwise it wraps.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned COEF_W   = 16,
    parameter int unsigned ACC_W    = 38,
    parameter int unsigned OUT_W    = 38,
    parameter int unsigned TAPS     = 64,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [IN_W-1:0]           in_data,
    input  logic [clog2_min1(CHANNELS)-1:0]  in_chan,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [OUT_W-1:0]          out_data,
    output logic [clog2_min1(CHANNELS)-1:0]  out_chan,
    input  logic                             coef_we,
    input  logic [clog2_min1(TAPS)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]         coef_data,
    output logic                             busy
);

    localparam int unsigned CH_W  = clog2_min1(CHANNELS);
    localparam int unsigned TAP_W = clog2_min1(TAPS);
    localparam int unsigned PW    = IN_W + COEF_W;
    localparam logic [CH_W:0]  CHAN_LIM = (CH_W + 1)'(CHANNELS);
    localparam logic [TAP_W:0] TAP_LIM  = (TAP_W + 1)'(TAPS);

    state_t state_q, state_nxt;

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic [TAP_W-1:0]         k_q;
    logic [CH_W-1:0]          chan_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [PW-1:0]     prod_q;
    logic                     prod_v_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic [CH_W-1:0]          out_chan_q;

    logic                     accept_ok;
    logic signed [IN_W-1:0]   rd_sample;
    logic signed [PW-1:0]     a_ext, b_ext, mul;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OUT_W-1:0]  out_next;

    assign in_ready  = (state_q == IDLE) && !clear;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    // Out-of-range channels complete the handshake but never start a MAC pass.
    assign accept_ok = in_valid && in_ready && ({1'b0, in_chan} < CHAN_LIM);

    fir_history_buf #(
        .IN_W     (IN_W),
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (accept_ok),
        .wr_chan (in_chan),
        .wr_data (in_data),
        .rd_chan (chan_q),
        .rd_k    (k_q),
        .rd_data (rd_sample)
    );

    always_comb begin
        a_ext   = PW'(rd_sample);
        b_ext   = PW'(coef_q[k_q]);
        mul     = a_ext * b_ext;
        acc_sum = acc_q + (prod_v_q ? ACC_W'(prod_q) : '0);
`ifdef FIR_SAT_EN
        out_next = OUT_W'(sat_to_width(SAT_MAX_W'(acc_sum), OUT_W));
`else
        out_next = OUT_W'(acc_sum);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept_ok) state_nxt = MAC;
            MAC:     if (k_q == TAP_W'(TAPS - 1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAPS; i++) coef_q[i] <= '0;
            k_q        <= '0;
            chan_q     <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            out_data_q <= '0;
            out_chan_q <= '0;
        end else begin
            if (coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < TAP_LIM))
                coef_q[coef_addr] <= coef_data;
            case (state_q)
                IDLE: begin
                    if (accept_ok) begin
                        chan_q   <= in_chan;
                        k_q      <= '0;
                        acc_q    <= '0;
                        prod_v_q <= 1'b0;
                    end
                end
                // Product of tap k is registered here and summed one cycle later.
                MAC: begin
                    prod_q   <= mul;
                    prod_v_q <= 1'b1;
                    acc_q    <= acc_sum;
                    k_q      <= k_q + TAP_W'(1);
                end
                DRAIN: begin
                    acc_q <= acc_sum;
                    if (!clear) begin
                        out_data_q <= out_next;
                        out_chan_q <= chan_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
module tb_fir_mac_engine;

    localparam int TAPS = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic [0:0]         in_chan;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [0:0]         out_chan;
    logic               coef_we;
    logic [5:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fir_mac_engine #(
        .IN_W     (16),
        .COEF_W   (16),
        .ACC_W    (38),
        .OUT_W    (16),
        .TAPS     (TAPS),
        .CHANNELS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [0:0]         ch;
        logic signed [15:0] din;
        logic signed [15:0] exp_out;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int a, input logic signed [15:0] d);
        coef_we   = 1'b1;
        coef_addr = 6'(a);
        coef_data = d;
        step();
        coef_we   = 1'b0;
    endtask

    // Offers one sample while idle with out_ready high; optionally pulses a
    // coefficient write we_at cycles after acceptance. lat counts the accept edge as 1.
    task automatic send(input logic [0:0] ch, input logic signed [15:0] d,
                        input int we_at, input int we_addr, input logic signed [15:0] we_data,
                        output logic signed [15:0] res, output logic [0:0] rch,
                        output int lat, output bit timed_out);
        in_chan  = ch;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        lat       = 1;
        timed_out = 1'b1;
        coef_addr = 6'(we_addr);
        coef_data = we_data;
        for (int c = 0; c < 200; c++) begin
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
            coef_we = (c == we_at);
            step();
            lat++;
        end
        coef_we = 1'b0;
        res = out_data;
        rch = out_chan;
        step();
    endtask

    logic signed [15:0] res;
    logic [0:0]         rch;
    int                 lat;
    bit                 tmo;
    vec_t               vecs [6];
    logic signed [15:0] held_d;
    logic [0:0]         held_c;
    bit                 seen;
    int                 exp_sat;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = '0;
        out_ready = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        vecs[0] = '{1'b0,  16'sd5,   16'sd5};
        vecs[1] = '{1'b1,  16'sd7,   16'sd7};
        vecs[2] = '{1'b0,  16'sd5,   16'sd10};
        vecs[3] = '{1'b1, -16'sd3,   16'sd4};
        vecs[4] = '{1'b0,  16'sd5,   16'sd15};
        vecs[5] = '{1'b1, -16'sd10, -16'sd6};

        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_data", out_data, 0);
        check("reset out_chan", out_chan, 0);

        // Impulse response: h[k] = k+1, channel 0 gets 1 then 63 zeros.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
        for (int i = 0; i < TAPS; i++) begin
            send(1'b0, (i == 0) ? 16'sd1 : 16'sd0, -1, 0, 16'sd0, res, rch, lat, tmo);
            check("impulse timeout", tmo, 0);
            check("impulse out_data", res, i + 1);
            check("impulse latency", lat, TAPS + 2);
        end

        clear = 1'b1; step(); clear = 1'b0;

        // Channel isolation, all-ones coefficients.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd1);
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].ch, vecs[i].din, -1, 0, 16'sd0, res, rch, lat, tmo);
            check("table timeout", tmo, 0);
            check("table out_data", res, vecs[i].exp_out);
            check("table out_chan", rch, vecs[i].ch);
            check("table idle after", busy, 0);
        end

        // Backpressure: ch1 history 7,-3,-10 plus new 4 gives -2.
        out_ready = 1'b0;
        in_chan = 1'b1; in_data = 16'sd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp in_ready after accept", in_ready, 0);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (out_valid) begin seen = 1'b1; break; end
            step();
        end
        check("bp out_valid", seen, 1);
        held_d = out_data;
        held_c = out_chan;
        check("bp out_data", held_d, -2);
        check("bp out_chan", held_c, 1);
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp hold valid", out_valid, 1);
            check("bp hold data", out_data, held_d);
            check("bp hold chan", out_chan, held_c);
            check("bp hold in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp release out_valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        check("bp release busy", busy, 0);

        // Coefficient write while busy is dropped; in IDLE it is applied.
        clear = 1'b1; step(); clear = 1'b0;
        send(1'b0, 16'sd2, 2, 0, 16'sd9, res, rch, lat, tmo);
        check("busy write timeout", tmo, 0);
        check("busy write dropped", res, 2);
        write_coef(0, 16'sd9);
        send(1'b0, 16'sd1, -1, 0, 16'sd0, res, rch, lat, tmo);
        check("idle write applied", res, 11);

        // Clear during MAC cycle 10.
        in_chan = 1'b0; in_data = 16'sd100; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        check("pre-clear busy", busy, 1);
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        check("clear blocks in_ready", in_ready, 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear -> idle", busy, 0);
        seen = 1'b0;
        for (int c = 0; c < TAPS + 10; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("clear no output", seen, 0);
        write_coef(0, 16'sd2);
        send(1'b0, 16'sd3, -1, 0, 16'sd0, res, rch, lat, tmo);
        check("post-clear out_data", res, 6);

        // Asynchronous reset mid-MAC.
        in_chan = 1'b1; in_data = 16'sd50; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst busy", busy, 0);
        check("async rst out_data", out_data, 0);
        check("async rst out_chan", out_chan, 0);
        step();
        rst_n = 1'b1;
        step();
        check("post-rst in_ready", in_ready, 1);
        send(1'b0, 16'sd123, -1, 0, 16'sd0, res, rch, lat, tmo);
        check("coef reset to zero", res, 0);

        // Saturation: each partial sum n*0x3FFF0001; low 16 bits are n.
        clear = 1'b1; step(); clear = 1'b0;
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sh7FFF);
        for (int i = 0; i < TAPS; i++) begin
            send(1'b0, 16'sh7FFF, -1, 0, 16'sd0, res, rch, lat, tmo);
`ifdef FIR_SAT_EN
            exp_sat = 32767;
`else
            exp_sat = i + 1;
`endif
            check("sat out_data", res, exp_sat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
